// File: rtl/stopwatch_pkg.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_pkg
// Brief    : State encodings, blank masks and helpers for the stopwatch controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] RUN     = 3'd1;
    localparam logic [STATE_W-1:0] PAUSE   = 3'd2;
    localparam logic [STATE_W-1:0] SET_MIN = 3'd3;
    localparam logic [STATE_W-1:0] SET_SEC = 3'd4;

    localparam logic [3:0] BLANK_MIN = 4'b1100;
    localparam logic [3:0] BLANK_SEC = 4'b0011;

    function automatic logic is_set_state(input logic [STATE_W-1:0] s);
        return (s == SET_MIN) || (s == SET_SEC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// Module   : btn_debounce
// Brief    : 2-FF synchronizer, stability counter and 1-cycle press pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_raw,
    output logic press_o
);

    localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // The pulse is registered alongside the level flip so it lines up with the new level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press_o = r_press;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_ctrl
// Brief    : RUN/PAUSE/SET sequencer for the MM:SS stopwatch; optional lap hold
//            output enabled by defining LAP_HOLD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       tick_o,
    output logic       clr_o,
    output logic       inc_min_o,
    output logic       inc_sec_o,
    output logic [3:0] blank_o,
    output logic       running_o,
`ifdef LAP_HOLD_EN
    output logic       hold_o,
`endif
    output logic [2:0] state_o
);

    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic                 w_press_start;
    logic                 w_press_mode;
    logic                 w_press_inc;
    logic                 w_go_start;
    logic                 w_go_mode;
    logic                 w_go_inc;
    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [c_presc_w-1:0] r_presc;
    logic                 w_presc_wrap;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink;
    logic                 r_tick;
    logic                 r_clr;
    logic                 r_inc_min;
    logic                 r_inc_sec;
    logic                 w_tick_nxt;
    logic                 w_clr_nxt;
    logic                 w_inc_min_nxt;
    logic                 w_inc_sec_nxt;
`ifdef LAP_HOLD_EN
    logic                 r_hold;
    logic                 w_hold_nxt;
`endif

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_start),
        .press_o (w_press_start)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_mode),
        .press_o (w_press_mode)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_inc),
        .press_o (w_press_inc)
    );

    // Only the strongest press of a cycle survives, even if the state ignores it.
    assign w_go_start   = w_press_start;
    assign w_go_mode    = w_press_mode & ~w_press_start;
    assign w_go_inc     = w_press_inc & ~w_press_mode & ~w_press_start;
    assign w_presc_wrap = (r_presc == c_presc_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = 1'b0;
        w_clr_nxt     = 1'b0;
        w_inc_min_nxt = 1'b0;
        w_inc_sec_nxt = 1'b0;
`ifdef LAP_HOLD_EN
        w_hold_nxt    = r_hold;
`endif
        case (r_state)
            IDLE: begin
                if (w_go_start)     w_state_nxt = RUN;
                else if (w_go_mode) w_state_nxt = SET_MIN;
            end
            RUN: begin
                w_tick_nxt = w_presc_wrap;
                if (w_go_start) w_state_nxt = PAUSE;
`ifdef LAP_HOLD_EN
                else if (w_go_inc) w_hold_nxt = ~r_hold;
`endif
            end
            PAUSE: begin
                if (w_go_start) begin
                    w_state_nxt = RUN;
                end else if (w_go_mode) begin
                    w_state_nxt = IDLE;
                    w_clr_nxt   = 1'b1;
                end
`ifdef LAP_HOLD_EN
                else if (w_go_inc && r_hold) w_hold_nxt = 1'b0;
`endif
            end
            SET_MIN: begin
                if (w_go_mode)     w_state_nxt   = SET_SEC;
                else if (w_go_inc) w_inc_min_nxt = 1'b1;
            end
            SET_SEC: begin
                if (w_go_mode)     w_state_nxt   = IDLE;
                else if (w_go_inc) w_inc_sec_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
`ifdef LAP_HOLD_EN
        if (w_state_nxt != RUN && w_state_nxt != PAUSE) w_hold_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_tick    <= 1'b0;
            r_clr     <= 1'b0;
            r_inc_min <= 1'b0;
            r_inc_sec <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_clr     <= w_clr_nxt;
            r_inc_min <= w_inc_min_nxt;
            r_inc_sec <= w_inc_sec_nxt;
        end
    end

    // PAUSE keeps the partial second; every non-run state restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            if (w_presc_wrap) r_presc <= '0;
            else              r_presc <= r_presc + 1'b1;
        end else if (r_state != PAUSE) begin
            r_presc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (is_set_state(r_state) && (w_state_nxt == r_state)) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end
    end

`ifdef LAP_HOLD_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_hold <= 1'b0;
        else       r_hold <= w_hold_nxt;
    end

    assign hold_o = r_hold;
`endif

    always_comb begin
        blank_o = 4'b0000;
        if (r_blink) begin
            if (r_state == SET_MIN)      blank_o = BLANK_MIN;
            else if (r_state == SET_SEC) blank_o = BLANK_SEC;
        end
    end

    assign tick_o    = r_tick;
    assign clr_o     = r_clr;
    assign inc_min_o = r_inc_min;
    assign inc_sec_o = r_inc_sec;
    assign running_o = (r_state == RUN);
    assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_stopwatch_ctrl
// Brief    : Scoreboard bench for stopwatch_ctrl with a behavioural reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int BLINK_DIV = 3;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_mode  = 1'b0;
    logic       btn_inc   = 1'b0;
    logic       tick_o;
    logic       clr_o;
    logic       inc_min_o;
    logic       inc_sec_o;
    logic [3:0] blank_o;
    logic       running_o;
    logic [2:0] state_o;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .tick_o    (tick_o),
        .clr_o     (clr_o),
        .inc_min_o (inc_min_o),
        .inc_sec_o (inc_sec_o),
        .blank_o   (blank_o),
        .running_o (running_o),
        .state_o   (state_o)
    );

    initial forever #5 clk = ~clk;

    // Strobe kinds: {tick, clr, inc_min, inc_sec}
    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: stopwatch state, accumulated run time, SET entry time, button windows
    logic [2:0]  m_state  = 3'd0;
    int          m_run    = 0;
    int          m_set_t0 = 0;
    logic [2:0]  m_db     = '0;
    logic [2:0]  m_pr     = '0;
    logic [15:0] m_hist [3];
    logic [2:0]  m_prev;
    logic [3:0]  m_ev;
    logic [2:0]  m_raw;
    bit          m_stable;

    initial begin : model
        for (int b = 0; b < 3; b++) m_hist[b] = '0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_state  = 3'd0;
                m_run    = 0;
                m_set_t0 = 0;
                m_db     = '0;
                m_pr     = '0;
                for (int b = 0; b < 3; b++) m_hist[b] = '0;
                q.delete();
            end else begin
                cyc++;
                m_prev = m_state;
                m_ev   = 4'b0000;
                if (m_state == 3'd1) begin
                    m_run++;
                    if (m_run % TICK_DIV == 0) m_ev = 4'b1000;
                end
                if (m_pr[0]) begin
                    case (m_state)
                        3'd0:    m_state = 3'd1;
                        3'd1:    m_state = 3'd2;
                        3'd2:    m_state = 3'd1;
                        default: ;
                    endcase
                end else if (m_pr[1]) begin
                    case (m_state)
                        3'd0: m_state = 3'd3;
                        3'd2: begin m_state = 3'd0; m_ev = 4'b0100; end
                        3'd3: m_state = 3'd4;
                        3'd4: m_state = 3'd0;
                        default: ;
                    endcase
                end else if (m_pr[2]) begin
                    if (m_state == 3'd3)      m_ev = 4'b0010;
                    else if (m_state == 3'd4) m_ev = 4'b0001;
                end
                if (m_state == 3'd0 || m_state >= 3'd3) m_run = 0;
                if (m_state >= 3'd3 && m_state != m_prev) m_set_t0 = cyc;
                if (m_ev != 4'b0000) q.push_back('{cyc, m_ev});
                // A level is accepted once the synchronised input held the new value for DB_CYCLES edges
                m_raw = {btn_inc, btn_mode, btn_start};
                m_pr  = '0;
                for (int b = 0; b < 3; b++) begin
                    m_hist[b] = {m_hist[b][14:0], m_raw[b]};
                    m_stable  = 1'b1;
                    for (int i = 2; i < DB_CYCLES + 2; i++)
                        if (m_hist[b][i] == m_db[b]) m_stable = 1'b0;
                    if (m_stable) begin
                        m_db[b] = ~m_db[b];
                        m_pr[b] = m_db[b];
                    end
                end
            end
        end
    end

    logic [3:0] mon_blank;
    logic [3:0] mon_ev;
    exp_t       mon_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rstn) begin
                mon_blank = 4'b0000;
                if (((cyc - m_set_t0) / BLINK_DIV) % 2 == 1) begin
                    if (m_state == 3'd3)      mon_blank = 4'b1100;
                    else if (m_state == 3'd4) mon_blank = 4'b0011;
                end
                n_vec++;
                if (state_o !== m_state || running_o !== (m_state == 3'd1) || blank_o !== mon_blank) begin
                    n_err++;
                    $display("FAIL status cyc=%0d: got state=%0d run=%b blank=%b, want state=%0d run=%b blank=%b",
                             cyc, state_o, running_o, blank_o, m_state, (m_state == 3'd1), mon_blank);
                end
                mon_ev = {tick_o, clr_o, inc_min_o, inc_sec_o};
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    mon_e = q.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL strobe_missing cyc=%0d: got nothing, want kind=%b", mon_e.cyc, mon_e.kind);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    mon_e = q.pop_front();
                    n_vec++;
                    if (mon_ev !== mon_e.kind) begin
                        n_err++;
                        $display("FAIL strobe cyc=%0d: got kind=%b, want kind=%b", cyc, mon_ev, mon_e.kind);
                    end
                end else if (mon_ev != 4'b0000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL strobe_unexpected cyc=%0d: got kind=%b, want 0000", cyc, mon_ev);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m);
        btn_start = m[0];
        btn_mode  = m[1];
        btn_inc   = m[2];
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        drive(m);
        step(hold);
        drive(3'b000);
        step(DB_CYCLES + 6);
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({tick_o, clr_o, inc_min_o, inc_sec_o, running_o, blank_o, state_o} !== 13'd0) begin
            n_err++;
            $display("FAIL %s: got outputs=%b, want all zero", tag,
                     {tick_o, clr_o, inc_min_o, inc_sec_o, running_o, blank_o, state_o});
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int lat;

    initial begin : stimulus
        drive(3'b000);
        step(3);
        check_zero("reset");
        rstn = 1'b1;
        step(2);

        // start latency: RUN visible DB_CYCLES+3 edges after the raw edge
        drive(3'b001);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && running_o) lat = i;
        end
        n_vec++;
        if (lat != DB_CYCLES + 3) begin
            n_err++;
            $display("FAIL start_latency: got %0d edges, want %0d", lat, DB_CYCLES + 3);
        end
        step(20);
        drive(3'b000);
        step(25);

        // pause mid-second, resume, pause, clear
        press(3'b001, 8);
        step(50);
        press(3'b001, 8);
        step(40);
        press(3'b001, 8);
        press(3'b010, 8);
        step(30);

        // set minutes x3, seconds x2, back to IDLE
        press(3'b010, 8);
        repeat (3) press(3'b100, 8);
        press(3'b010, 8);
        repeat (2) press(3'b100, 8);
        press(3'b010, 8);

        // bouncing inc in SET_MIN gives a single press
        press(3'b010, 8);
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 3'b100 : 3'b000);
            step(2);
        end
        drive(3'b100);
        step(20);
        drive(3'b000);
        step(10);
        press(3'b010, 8);
        press(3'b010, 8);

        // start and mode together from IDLE: start wins
        press(3'b011, 8);
        step(15);

        // async reset mid-RUN
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        step(1);
        step(1);
        rstn = 1'b1;
        step(2);
        press(3'b001, 8);
        step(30);
        press(3'b001, 8);
        press(3'b010, 8);

        // random button traffic, including short bouncy holds
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 2) == 0) drive(3'b000);
            else                           drive(3'($urandom_range(0, 7)));
            step($urandom_range(1, 12));
        end
        drive(3'b000);
        step(20);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending strobes, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
